// File: rtl/demux_8_sched.sv
// Round-robin burst scheduler for an 8-way demux: visits each enabled channel in turn
// and moves up to len words per visit through a one-word output register.
module demux_8_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_W    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [7:0]            enable_mask_i,
    input  logic [BURST_W-1:0]    burst_len_i,
    input  logic                  s_valid_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  s_ready_o,
    output logic [2:0]            select_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic [7:0]            m_valid_o,
    input  logic [7:0]            m_ready_i,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEEK = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t             state;
    logic [2:0]         ptr;
    logic [BURST_W-1:0] cnt;
    logic [BURST_W-1:0] len;

    logic [2:0] seek_ch;
    logic       seek_hit;
    logic       sel_rdy;
    logic       out_empty;
    logic       hs;
    logic       accept;
    logic       done;

    // First enabled channel at or after ptr, wrapping 7 -> 0.
    always_comb begin
        seek_ch  = ptr;
        seek_hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!seek_hit && enable_mask_i[ptr + 3'(i)]) begin
                seek_ch  = ptr + 3'(i);
                seek_hit = 1'b1;
            end
        end
    end

    assign sel_rdy   = m_ready_i[select_o];
    assign out_empty = (m_valid_o == 8'd0);
    assign hs        = m_valid_o[select_o] && sel_rdy;
    assign s_ready_o = (state == XFER) && (cnt < len) && (out_empty || sel_rdy);
    assign accept    = s_valid_i && s_ready_o;
    // Once the last word is accepted, the burst closes when the register drains.
    assign done      = (state == XFER) && (cnt == len) && (out_empty || hs);
    assign busy_o    = (state != IDLE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            cnt       <= '0;
            len       <= '0;
            select_o  <= 3'd0;
            m_data_o  <= '0;
            m_valid_o <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable_mask_i != 8'd0) state <= SEEK;
                end
                SEEK: begin
                    if (seek_hit) begin
                        select_o <= seek_ch;
                        len      <= (burst_len_i == '0) ? BURST_W'(1) : burst_len_i;
                        cnt      <= '0;
                        state    <= XFER;
                    end else begin
                        state <= IDLE;
                    end
                end
                XFER: begin
                    // A same-cycle accept overwrites the word being handed off.
                    if (accept) begin
                        m_data_o  <= s_data_i;
                        m_valid_o <= 8'd1 << select_o;
                        cnt       <= cnt + BURST_W'(1);
                    end else if (hs) begin
                        m_valid_o <= 8'd0;
                    end
                    if (done) begin
                        ptr   <= select_o + 3'd1;
                        state <= SEEK;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_demux_8_sched.sv
// Bench for demux_8_sched: table-driven schedule vectors, hand-written corner sequences,
// and randomized traffic checked against a word-level round-robin model.
module tb_demux_8_sched;
    localparam int DW = 8;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst_n_i;
    logic [7:0]    enable_mask_i;
    logic [BW-1:0] burst_len_i;
    logic          s_valid_i;
    logic [DW-1:0] s_data_i;
    logic          s_ready_o;
    logic [2:0]    select_o;
    logic [DW-1:0] m_data_o;
    logic [7:0]    m_valid_o;
    logic [7:0]    m_ready_i;
    logic          busy_o;

    demux_8_sched #(.DATA_WIDTH(DW), .BURST_W(BW)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .enable_mask_i(enable_mask_i),
        .burst_len_i(burst_len_i), .s_valid_i(s_valid_i), .s_data_i(s_data_i),
        .s_ready_o(s_ready_o), .select_o(select_o), .m_data_o(m_data_o),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // seq: expected channel of words 1..12, first word in the top nibble
    typedef struct packed {
        logic [7:0]  mask;
        logic [3:0]  len;
        logic [47:0] seq;
    } vec_t;
    vec_t tbl [7];

    int checks = 0;
    int errors = 0;
    int hs_ch[$], hs_dat[$], hs_cyc[$], sent[$];
    logic [7:0]    allowed = 8'hFF;
    bit            rand_mode = 1'b0;
    bit            prev_stall = 1'b0;
    logic [7:0]    pv_valid;
    logic [DW-1:0] pv_data;
    logic [2:0]    pv_sel;
    logic [7:0]    smp_valid;
    logic [DW-1:0] smp_data;
    logic          smp_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: sample at negedge, record handshakes/accepts, drive after posedge.
    task automatic step();
        logic acc, hs, stall;
        @(negedge clk);
        acc   = s_valid_i && s_ready_o;
        hs    = m_valid_o[select_o] && m_ready_i[select_o];
        stall = (m_valid_o != 8'd0) && !m_ready_i[select_o];
        smp_valid = m_valid_o;
        smp_data  = m_data_o;
        smp_rdy   = s_ready_o;
        chk("onehot", 32'(m_valid_o & ~(8'd1 << select_o)), 32'd0);
        chk("allowed", 32'(m_valid_o & ~allowed), 32'd0);
        if (prev_stall) begin
            chk("hold_valid", 32'(m_valid_o), 32'(pv_valid));
            chk("hold_data", 32'(m_data_o), 32'(pv_data));
            chk("hold_sel", 32'(select_o), 32'(pv_sel));
        end
        if (stall) chk("stall_rdy", 32'(s_ready_o), 32'd0);
        prev_stall = stall;
        pv_valid = m_valid_o;
        pv_data  = m_data_o;
        pv_sel   = select_o;
        if (hs) begin
            hs_ch.push_back(int'(select_o));
            hs_dat.push_back(int'(m_data_o));
            hs_cyc.push_back(cyc);
        end
        if (acc) sent.push_back(int'(s_data_i));
        @(posedge clk);
        #1;
        if (rand_mode) begin
            s_valid_i = ($urandom_range(0, 3) != 0);
            m_ready_i = 8'($urandom);
            if (acc) s_data_i = DW'($urandom);
        end else if (acc) begin
            s_data_i = s_data_i + 1'b1;
        end
    endtask

    task automatic run(input int n, input int budget);
        int b = 0;
        while (hs_ch.size() < n && b < budget) begin
            step();
            b++;
        end
        chk("hs_timeout", 32'(hs_ch.size()), 32'(n));
    endtask

    task automatic wait_valid(input logic [7:0] tgt, input int budget);
        int b = 0;
        smp_valid = 8'd0;
        while (smp_valid != tgt && b < budget) begin
            step();
            b++;
        end
        chk("valid_timeout", 32'(smp_valid), 32'(tgt));
    endtask

    task automatic clear_log();
        hs_ch.delete();
        hs_dat.delete();
        hs_cyc.delete();
        sent.delete();
        prev_stall = 1'b0;
    endtask

    task automatic rst_dut();
        rst_n_i   = 1'b0;
        s_valid_i = 1'b0;
        s_data_i  = 8'd1;
        m_ready_i = 8'hFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n_i = 1'b1;
        clear_log();
    endtask

    // Word k of a burst stream goes to the (k / len)-th enabled channel in ascending order.
    function automatic int model_ch(input logic [7:0] mask, input logic [3:0] len, input int k);
        int chs[$];
        int l;
        l = (len == 4'd0) ? 1 : int'(len);
        for (int c = 0; c < 8; c++) if (mask[c]) chs.push_back(c);
        return chs[(k / l) % chs.size()];
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int l;
        int mc_exp[5] = '{0, 0, 0, 0, 1};
        logic [7:0] rmask;
        logic [3:0] rlen;

        tbl[0] = '{8'hFF, 4'd1, 48'h0123_4567_0123};
        tbl[1] = '{8'hA4, 4'd3, 48'h2225_5577_7222};
        tbl[2] = '{8'h03, 4'd0, 48'h0101_0101_0101};
        tbl[3] = '{8'h01, 4'd4, 48'h0000_0000_0000};
        tbl[4] = '{8'h11, 4'd5, 48'h0000_0444_4400};
        tbl[5] = '{8'h80, 4'd2, 48'h7777_7777_7777};
        tbl[6] = '{8'h48, 4'd2, 48'h3366_3366_3366};

        rst_n_i = 1'b0;
        enable_mask_i = 8'd0;
        burst_len_i = 4'd1;
        s_valid_i = 1'b0;
        s_data_i = 8'd1;
        m_ready_i = 8'hFF;
        #12;
        chk("rst_select", 32'(select_o), 32'd0);
        chk("rst_data", 32'(m_data_o), 32'd0);
        chk("rst_valid", 32'(m_valid_o), 32'd0);
        chk("rst_sready", 32'(s_ready_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);

        // Empty mask keeps the scheduler idle.
        rst_dut();
        s_valid_i = 1'b1;
        repeat (3) step();
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_sready", 32'(s_ready_o), 32'd0);

        for (int t = 0; t < 7; t++) begin
            rst_dut();
            allowed = tbl[t].mask;
            enable_mask_i = tbl[t].mask;
            burst_len_i = tbl[t].len;
            s_valid_i = 1'b1;
            run(12, 200);
            l = (tbl[t].len == 4'd0) ? 1 : int'(tbl[t].len);
            for (int k = 0; k < 12 && k < hs_ch.size(); k++) begin
                chk($sformatf("t%0d_ch%0d", t, k), 32'(hs_ch[k]), 32'(tbl[t].seq[44-4*k +: 3]));
                chk($sformatf("t%0d_dat%0d", t, k), 32'(hs_dat[k]), 32'(k + 1));
                if (k > 0)
                    chk($sformatf("t%0d_gap%0d", t, k), 32'(hs_cyc[k] - hs_cyc[k-1]),
                        (k % l == 0) ? 32'd3 : 32'd1);
            end
            s_valid_i = 1'b0;
        end
        allowed = 8'hFF;

        // Backpressure on channel 0.
        rst_dut();
        enable_mask_i = 8'h01;
        burst_len_i = 4'd4;
        m_ready_i = 8'hFE;
        s_valid_i = 1'b1;
        wait_valid(8'h01, 20);
        repeat (5) begin
            step();
            chk("bp_valid", 32'(smp_valid), 32'h01);
            chk("bp_data", 32'(smp_data), 32'd1);
            chk("bp_sready", 32'(smp_rdy), 32'd0);
        end
        m_ready_i = 8'hFF;
        run(4, 50);
        for (int k = 0; k < hs_ch.size(); k++) begin
            chk($sformatf("bp_ch%0d", k), 32'(hs_ch[k]), 32'd0);
            chk($sformatf("bp_dat%0d", k), 32'(hs_dat[k]), 32'(k + 1));
        end

        // Mask change mid-burst takes effect only at the next seek.
        rst_dut();
        enable_mask_i = 8'h01;
        burst_len_i = 4'd4;
        s_valid_i = 1'b1;
        run(1, 30);
        enable_mask_i = 8'h02;
        run(5, 50);
        for (int k = 0; k < hs_ch.size(); k++) begin
            chk($sformatf("mc_ch%0d", k), 32'(hs_ch[k]), 32'(mc_exp[k]));
            chk($sformatf("mc_dat%0d", k), 32'(hs_dat[k]), 32'(k + 1));
        end

        // Asynchronous reset while channel 4 holds a word.
        rst_dut();
        enable_mask_i = 8'h1C;
        burst_len_i = 4'd1;
        s_valid_i = 1'b1;
        run(2, 40);
        if (hs_ch.size() == 2) begin
            chk("ar_pre_ch0", 32'(hs_ch[0]), 32'd2);
            chk("ar_pre_ch1", 32'(hs_ch[1]), 32'd3);
        end
        m_ready_i = 8'hEF;
        wait_valid(8'h10, 30);
        rst_n_i = 1'b0;
        #1;
        chk("ar_valid", 32'(m_valid_o), 32'd0);
        chk("ar_data", 32'(m_data_o), 32'd0);
        chk("ar_select", 32'(select_o), 32'd0);
        chk("ar_sready", 32'(s_ready_o), 32'd0);
        chk("ar_busy", 32'(busy_o), 32'd0);
        enable_mask_i = 8'h14;
        m_ready_i = 8'hFF;
        s_data_i = 8'h40;
        @(negedge clk);
        rst_n_i = 1'b1;
        clear_log();
        run(1, 30);
        if (hs_ch.size() == 1) begin
            chk("ar_post_ch", 32'(hs_ch[0]), 32'd2);
            chk("ar_post_dat", 32'(hs_dat[0]), 32'h40);
        end

        // Randomized traffic against the round-robin model.
        for (int seg = 0; seg < 20; seg++) begin
            rst_dut();
            rmask = 8'($urandom_range(1, 255));
            rlen = 4'($urandom_range(0, 15));
            allowed = rmask;
            enable_mask_i = rmask;
            burst_len_i = rlen;
            s_valid_i = 1'b1;
            s_data_i = DW'($urandom);
            m_ready_i = 8'($urandom);
            rand_mode = 1'b1;
            run(30, 1500);
            rand_mode = 1'b0;
            for (int k = 0; k < hs_ch.size(); k++) begin
                chk($sformatf("r%0d_ch%0d", seg, k), 32'(hs_ch[k]), 32'(model_ch(rmask, rlen, k)));
                if (k < sent.size())
                    chk($sformatf("r%0d_dat%0d", seg, k), 32'(hs_dat[k]), 32'(sent[k]));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
